// File: rtl/bank_serializer.sv
// Snapshots a parallel bank of DEPTH words on start_i and streams them out one word per transfer.
// Define BANK_SERIALIZER_SUM_EN to add sum_o, the running sum of the transferred words.
module bank_serializer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             start_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]      data_i,
    input  logic                             ready_i,
    output logic                             valid_o,
    output logic [WIDTH-1:0]                 data_o,
    output logic [$clog2(DEPTH)-1:0]         index_o,
    output logic                             last_o,
    output logic                             busy_o,
`ifdef BANK_SERIALIZER_SUM_EN
    output logic                             done_o,
    output logic [WIDTH+$clog2(DEPTH)-1:0]   sum_o
`else
    output logic                             done_o
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nx;
    logic [IW-1:0]                 r_idx;
    logic [IW-1:0]                 w_idx_nx;
    logic [DEPTH-1:0][WIDTH-1:0]   r_snap;
    logic                          w_capture;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_capture  = 1'b1;
                    w_idx_nx   = '0;
                    w_state_nx = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nx = DONE;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_snap <= '0;
        end else if (w_capture) begin
            r_snap <= data_i;
        end
    end

    // Outputs are registered from the next state; on capture the first word comes straight from data_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            last_o  <= 1'b0;
            data_o  <= '0;
            index_o <= '0;
        end else begin
            valid_o <= (w_state_nx == SEND);
            busy_o  <= (w_state_nx != IDLE);
            done_o  <= (w_state_nx == DONE);
            last_o  <= (w_state_nx == SEND) && (w_idx_nx == LAST_IDX);
            if (w_state_nx == SEND) begin
                index_o <= w_idx_nx;
                data_o  <= w_capture ? data_i[0] : r_snap[w_idx_nx];
            end
        end
    end

`ifdef BANK_SERIALIZER_SUM_EN
    logic [WIDTH+IW-1:0] r_sum;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sum <= '0;
        end else if (w_capture) begin
            r_sum <= '0;
        end else if (valid_o && ready_i) begin
            r_sum <= r_sum + (WIDTH + IW)'(data_o);
        end
    end

    assign sum_o = r_sum;
`endif

endmodule

// File: tb/tb_bank_serializer.sv
// Scoreboard bench for bank_serializer (default 32x4): expected words are queued at start capture
// and compared as each transfer happens; a small bench-side FSM model checks valid/busy/done/last.
module tb_bank_serializer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int IW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   ready;
    logic [D-1:0][W-1:0]    din;
    logic                   valid;
    logic [W-1:0]           dout;
    logic [IW-1:0]          idx;
    logic                   last;
    logic                   busy;
    logic                   done;
`ifdef BANK_SERIALIZER_SUM_EN
    logic [W+IW-1:0]        sum;
`endif

    bank_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .data_i  (din),
        .ready_i (ready),
        .valid_o (valid),
        .data_o  (dout),
        .index_o (idx),
        .last_o  (last),
        .busy_o  (busy),
`ifdef BANK_SERIALIZER_SUM_EN
        .done_o  (done),
        .sum_o   (sum)
`else
        .done_o  (done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    typedef enum {M_IDLE, M_SEND, M_DONE} mstate_t;

    exp_t             sb[$];
    mstate_t          m = M_IDLE;
    int               n_checks = 0;
    int               n_fail = 0;
    int               cyc = 0;
    logic [W+IW-1:0]  exp_sum = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_bank(input logic [D-1:0][W-1:0] b);
        exp_sum = '0;
        for (int i = 0; i < D; i++) begin
            sb.push_back('{d: b[i], i: IW'(i), l: (i == D - 1)});
            exp_sum = exp_sum + (W + IW)'(b[i]);
        end
    endtask

    // Called just after a falling edge with inputs already set for the coming rising edge.
    task automatic tick();
        exp_t          e;
        logic          hold;
        logic [W-1:0]  hd;
        logic [IW-1:0] hi;
        hold = 1'b0;
        hd   = '0;
        hi   = '0;
        if (rst_n) begin
            case (m)
                M_IDLE: begin
                    if (start) begin
                        push_bank(din);
                        m = M_SEND;
                    end
                end
                M_SEND: begin
                    if (ready) begin
                        if (sb.size() == 0) begin
                            check("sb_underflow", 1, 0);
                            m = M_DONE;
                        end else begin
                            e = sb.pop_front();
                            check("data_o", dout, e.d);
                            check("index_o", idx, e.i);
                            check("last_o", last, e.l);
                            if (e.l) m = M_DONE;
                        end
                    end else begin
                        hold = 1'b1;
                        hd   = dout;
                        hi   = idx;
                    end
                end
                M_DONE: m = M_IDLE;
                default: m = M_IDLE;
            endcase
        end
        @(negedge clk);
        cyc++;
        check("valid_o", valid, (m == M_SEND));
        check("busy_o", busy, (m != M_IDLE));
        check("done_o", done, (m == M_DONE));
        if (m != M_SEND) check("last_o_idle", last, 0);
        if (hold) begin
            check("hold_data_o", dout, hd);
            check("hold_index_o", idx, hi);
        end
`ifdef BANK_SERIALIZER_SUM_EN
        if (m == M_DONE) check("sum_o", sum, exp_sum);
`endif
    endtask

    task automatic run_until_idle();
        for (int k = 0; k < 40 && m != M_IDLE; k++) tick();
        check("idle_reached", (m == M_IDLE), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_data"}, dout, 0);
        check({tag, "_index"}, idx, 0);
`ifdef BANK_SERIALIZER_SUM_EN
        check({tag, "_sum"}, sum, 0);
`endif
    endtask

    task automatic load_bank(input int base);
        for (int i = 0; i < D; i++) din[i] = W'(base + i);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        din   = '0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // basic stream and latency
        load_bank(1);
        ready = 1'b1;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && m != M_DONE; k++) tick();
        check("done_latency", cyc - c0, D + 1);
        tick();
        check("idle_hold_data", dout, 4);
        check("idle_hold_index", idx, 3);

        // backpressure at idx 1
        load_bank(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        run_until_idle();

        // snapshot isolation
        load_bank(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        din = '1;
        run_until_idle();

        // start held high through the stream
        load_bank(1);
        start = 1'b1;
        tick();
        load_bank(5);
        repeat (4) tick();
        check("busy_done_pulse", done, 1);
        tick();
        tick();
        check("restart_index", idx, 0);
        check("restart_data", dout, 5);
        start = 1'b0;
        run_until_idle();

        // reset mid-stream at idx 2
        load_bank(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("pre_reset_index", idx, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        m = M_IDLE;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        load_bank(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_reset_index", idx, 0);
        run_until_idle();

`ifdef BANK_SERIALIZER_SUM_EN
        din = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_idle();
        check("sum_all_ones", sum, 34'h3_FFFF_FFFC);
`endif

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
